player_sprite: RTL and testbench

Pixel-clock renderer that sits directly downstream of the ball position/motion block. It consumes the player's Ball_X/Ball_Y/Start, snapshots position once per frame at the start of vertical blanking, and runs an animation FSM (idle/stand/walk/air plus facing). For every DrawX/DrawY from the VGA controller it generates a sprite ROM address and outputs a pipelined palette index and an opaque flag to the colour mapper.

---
 rtl/player_sprite.sv | 158 +++++++++++++++
 tb/tb_player_sprite.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/player_sprite.sv
// Player sprite renderer: latches the player position once per frame at the VS falling edge,
// runs the idle/stand/walk/air animation FSM and produces a 3-stage pipelined palette lookup.
module player_sprite #(
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int WALK_FRAMES = 4,
  parameter int ANIM_DIV    = 6,
  parameter int GROUND_Y    = 250,
  parameter int INIT_X      = 40,
  parameter int INIT_Y      = 250,
  parameter int TRANSPARENT = 0,
  parameter int ROM_ADDR_W  = 13
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  VS,
  input  logic                  Start,
  input  logic [9:0]            Ball_X,
  input  logic [9:0]            Ball_Y,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [3:0]            rom_data,
  output logic                  pixel_on,
  output logic [3:0]            pixel_idx,
  output logic [1:0]            anim_state
);

  localparam int XB = $clog2(SPRITE_W);
  localparam int YB = $clog2(SPRITE_H);
  localparam int FB = $clog2(WALK_FRAMES + 2);
  localparam int WB = (WALK_FRAMES > 1) ? $clog2(WALK_FRAMES) : 1;
  localparam int DB = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STAND = 2'd1,
    S_WALK  = 2'd2,
    S_AIR   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_vs_prev;
  logic                  r_facing_left;
  logic [9:0]            r_pos_x;
  logic [9:0]            r_pos_y;
  logic [WB-1:0]         r_walk_frame;
  logic [DB-1:0]         r_div_cnt;
  logic                  r_v1;
  logic                  r_v2;

  logic                  w_tick;
  logic signed [10:0]    w_dx;
  logic signed [10:0]    w_rx;
  logic signed [10:0]    w_ry;
  logic                  w_in_box;
  logic [XB-1:0]         w_col;
  logic [FB-1:0]         w_f;
  logic [ROM_ADDR_W-1:0] w_addr;

  assign w_tick     = r_vs_prev & ~VS;
  assign w_dx       = {1'b0, Ball_X} - {1'b0, r_pos_x};
  assign anim_state = r_state;

  // Next animation state, evaluated against the incoming position at the frame tick
  always_comb begin
    w_next_state = S_STAND;
    if (!Start) begin
      w_next_state = S_IDLE;
    end else if (Ball_Y < 10'(GROUND_Y)) begin
      w_next_state = S_AIR;
    end else if (w_dx != 11'sd0) begin
      w_next_state = S_WALK;
    end else begin
      w_next_state = S_STAND;
    end
  end

  // Per-frame snapshot of position, facing and walk-cycle counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vs_prev     <= 1'b1;
      r_pos_x       <= 10'(INIT_X);
      r_pos_y       <= 10'(INIT_Y);
      r_state       <= S_IDLE;
      r_facing_left <= 1'b0;
      r_walk_frame  <= {WB{1'b0}};
      r_div_cnt     <= {DB{1'b0}};
    end else begin
      r_vs_prev <= VS;
      if (w_tick) begin
        r_pos_x <= Ball_X;
        r_pos_y <= Ball_Y;
        r_state <= w_next_state;
        if (w_dx[10]) begin
          r_facing_left <= 1'b1;
        end else if (w_dx != 11'sd0) begin
          r_facing_left <= 1'b0;
        end else begin
          r_facing_left <= r_facing_left;
        end
        // Only a tick that stays in WALK advances the cycle; entry and exit restart it
        if (w_next_state == S_WALK && r_state == S_WALK) begin
          if (r_div_cnt == DB'(ANIM_DIV - 1)) begin
            r_div_cnt <= {DB{1'b0}};
            if (r_walk_frame == WB'(WALK_FRAMES - 1)) begin
              r_walk_frame <= {WB{1'b0}};
            end else begin
              r_walk_frame <= r_walk_frame + WB'(1);
            end
          end else begin
            r_div_cnt <= r_div_cnt + DB'(1);
          end
        end else begin
          r_div_cnt    <= {DB{1'b0}};
          r_walk_frame <= {WB{1'b0}};
        end
      end
    end
  end

  // Sprite frame selection and box test for the current draw position
  always_comb begin
    w_f = {FB{1'b0}};
    case (r_state)
      S_WALK:  w_f = FB'(1) + FB'(r_walk_frame);
      S_AIR:   w_f = FB'(WALK_FRAMES + 1);
      default: w_f = {FB{1'b0}};
    endcase
  end

  assign w_rx     = {1'b0, DrawX} - {1'b0, r_pos_x};
  assign w_ry     = {1'b0, DrawY} - {1'b0, r_pos_y};
  assign w_in_box = !w_rx[10] && (w_rx < 11'(SPRITE_W)) && !w_ry[10] && (w_ry < 11'(SPRITE_H));
  assign w_col    = r_facing_left ? (XB'(SPRITE_W - 1) - w_rx[XB-1:0]) : w_rx[XB-1:0];
  assign w_addr   = ROM_ADDR_W'(w_f) * ROM_ADDR_W'(SPRITE_W * SPRITE_H)
                  + ROM_ADDR_W'(w_ry[YB-1:0]) * ROM_ADDR_W'(SPRITE_W)
                  + ROM_ADDR_W'(w_col);

  // Address, ROM wait and palette output stages
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= {ROM_ADDR_W{1'b0}};
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      pixel_on  <= 1'b0;
      pixel_idx <= 4'd0;
    end else begin
      rom_addr  <= w_in_box ? w_addr : {ROM_ADDR_W{1'b0}};
      r_v1      <= w_in_box;
      r_v2      <= r_v1;
      pixel_on  <= r_v2 && (rom_data != 4'(TRANSPARENT));
      pixel_idx <= r_v2 ? rom_data : 4'd0;
    end
  end

endmodule

// File: tb/tb_player_sprite.sv
// Randomized scoreboard bench for player_sprite against a frame-level reference model.
module tb_player_sprite;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        VS;
  logic        Start;
  logic [9:0]  Ball_X, Ball_Y, DrawX, DrawY;
  logic [12:0] rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic        pixel_on;
  logic [3:0]  pixel_idx;
  logic [1:0]  anim_state;

  always #5 Clk = ~Clk;

  player_sprite dut (
    .Clk(Clk), .Reset_n(Reset_n), .VS(VS), .Start(Start),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_on(pixel_on), .pixel_idx(pixel_idx), .anim_state(anim_state)
  );

  logic [3:0] mem [0:8191];
  always @(posedge Clk) rom_data <= mem[rom_addr];

  typedef struct {
    int         t;
    logic [12:0] addr;
    logic [1:0]  st;
    logic        on;
    logic [3:0]  idx;
  } exp_t;

  exp_t q_a[$];
  exp_t q_p[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // reference model state
  int m_px, m_py, m_st, m_wf, m_dc;
  bit m_left, m_prev_vs;

  task automatic model_reset();
    m_px = 40; m_py = 250; m_st = 0; m_wf = 0; m_dc = 0;
    m_left = 1'b0; m_prev_vs = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // mode: 0 random near box, 1 fixed (ox,oy), 2 sprite origin, 3 left of box, 4 right of box
  task automatic drive_cycle(input logic vs, input int bx, input int by, input logic st,
                             input int mode, input int ox, input int oy);
    exp_t e;
    int rx, ry, f, col, addr, dx, ns;
    bit inb;
    @(negedge Clk);
    VS = vs; Ball_X = 10'(bx); Ball_Y = 10'(by); Start = st;
    case (mode)
      1: begin DrawX = 10'(ox); DrawY = 10'(oy); end
      2: begin DrawX = 10'(m_px); DrawY = 10'(m_py); end
      3: begin DrawX = 10'(m_px - 1); DrawY = 10'(m_py + 4); end
      4: begin DrawX = 10'(m_px + 32); DrawY = 10'(m_py + 4); end
      default: begin
        if ($urandom_range(0, 3) == 0) begin
          DrawX = 10'($urandom_range(0, 1023)); DrawY = 10'($urandom_range(0, 1023));
        end else begin
          DrawX = 10'(m_px + int'($urandom_range(0, 40)) - 4);
          DrawY = 10'(m_py + int'($urandom_range(0, 40)) - 4);
        end
      end
    endcase
    rx  = int'(DrawX) - m_px;
    ry  = int'(DrawY) - m_py;
    inb = (rx >= 0) && (rx < 32) && (ry >= 0) && (ry < 32);
    f   = (m_st == 2) ? 1 + m_wf : (m_st == 3) ? 5 : 0;
    col = m_left ? 31 - rx : rx;
    addr = inb ? f * 1024 + ry * 32 + col : 0;
    e.t    = cyc + 1;
    e.addr = 13'(addr);
    e.on   = inb && (mem[addr] != 4'd0);
    e.idx  = inb ? mem[addr] : 4'd0;
    if (m_prev_vs && !vs) begin
      dx = bx - m_px;
      if (dx < 0) m_left = 1'b1;
      else if (dx > 0) m_left = 1'b0;
      ns = !st ? 0 : (by < 250) ? 3 : (dx != 0) ? 2 : 1;
      if (ns == 2 && m_st == 2) begin
        m_dc = m_dc + 1;
        if (m_dc == 6) begin m_dc = 0; m_wf = (m_wf + 1) % 4; end
      end else begin
        m_dc = 0; m_wf = 0;
      end
      m_st = ns; m_px = bx; m_py = by;
    end
    m_prev_vs = vs;
    e.st = 2'(m_st);
    q_a.push_back(e);
    q_p.push_back(e);
  endtask

  // One frame: VS falls two cycles before the end; Ball is junk except at the tick
  task automatic run_frame(input int tx, input int ty, input logic st,
                           input int mode = 0, input int ox = 0, input int oy = 0);
    int len = 20;
    for (int c = 0; c < len; c++) begin
      logic vs;
      int bx, by, md;
      vs = !(c >= len - 2);
      bx = tx; by = ty;
      if (c != len - 2 && $urandom_range(0, 1) == 1) begin
        bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
      end
      md = (c >= 3 && c <= 5) ? mode : 0;
      drive_cycle(vs, bx, by, st, md, ox, oy);
    end
  endtask

  // Monitor: pops expectations as the DUT presents address and pixel results
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc = cyc + 1;
      #1;
      if (q_a.size() > 0 && q_a[0].t <= cyc) begin
        e = q_a.pop_front();
        chk("rom_addr", 32'(rom_addr), 32'(e.addr));
        chk("anim_state", 32'(anim_state), 32'(e.st));
      end
      if (q_p.size() > 0 && q_p[0].t + 2 <= cyc) begin
        e = q_p.pop_front();
        chk("pixel_on", 32'(pixel_on), 32'(e.on));
        chk("pixel_idx", 32'(pixel_idx), 32'(e.idx));
      end
    end
  end

  initial begin
    int x;
    for (int i = 0; i < 8192; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    mem[325] = 4'd7;
    Reset_n = 1'b0; VS = 1'b1; Start = 1'b0;
    Ball_X = 10'd0; Ball_Y = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
    model_reset();
    repeat (6) begin @(negedge Clk); VS = ~VS; DrawX = 10'd45; DrawY = 10'd255; end
    #1;
    chk("reset_pixel_on", 32'(pixel_on), 32'd0);
    chk("reset_pixel_idx", 32'(pixel_idx), 32'd0);
    chk("reset_anim_state", 32'(anim_state), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge Clk); VS = 1'b1; Reset_n = 1'b1;

    run_frame(100, 250, 1'b0);
    repeat (2) run_frame(100, 250, 1'b1);
    run_frame(100, 250, 1'b1, 1, 105, 260);
    x = 100;
    for (int k = 0; k < 26; k++) begin x = x + 5; run_frame(x, 250, 1'b1); end
    for (int k = 0; k < 8; k++) begin x = x - 5; run_frame(x, 250, 1'b1, 2); end
    repeat (2) run_frame(x, 250, 1'b1, 2);
    repeat (2) run_frame(x, 200, 1'b1, 3);
    repeat (2) run_frame(x, 250, 1'b1, 4);
    repeat (2) run_frame(620, 250, 1'b1, 1, 639, 260);
    repeat (2) run_frame(3, 250, 1'b1, 3);
    for (int k = 0; k < 20; k++)
      run_frame($urandom_range(0, 1023), $urandom_range(150, 300), 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 4) == 0 ? 2 : 0);

    // asynchronous reset in mid-line flushes the pipeline immediately
    @(negedge Clk); #2 Reset_n = 1'b0;
    #1;
    chk("midreset_pixel_on", 32'(pixel_on), 32'd0);
    chk("midreset_rom_addr", 32'(rom_addr), 32'd0);
    chk("midreset_anim_state", 32'(anim_state), 32'd0);
    q_a.delete(); q_p.delete();
    repeat (4) begin @(negedge Clk); VS = ~VS; end
    @(negedge Clk); VS = 1'b1; Reset_n = 1'b1;
    model_reset();
    repeat (3) run_frame(60, 250, 1'b1, 2);
    for (int k = 0; k < 8; k++) run_frame(60 + 7 * k, 250, 1'b1);

    repeat (6) @(negedge Clk);
    n_cmp = n_cmp + 1;
    if (q_a.size() != 0 || q_p.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q_a.size(), q_p.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
